// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
// keypad_scanner: 4x4 matrix keypad scanner with press/release debounce.
//   Drives one active-low column per slot, samples the synchronized rows at
//   slot end, debounces a single key and reports it as key_code with a
//   one-cycle key_valid pulse. Codes 0..3 select a one-hot peripheral on
//   module_sel, code 12 deselects all, other codes leave module_sel alone.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   row[3:0]         : active-low row lines (asynchronous)
//   col[3:0]         : active-low column drive, one bit low
//   key_valid        : one-cycle pulse per confirmed press
//   key_code[3:0]    : row*4+col of the last confirmed key
//   module_sel[3:0]  : one-hot peripheral select, zero = none
module keypad_scanner #(
   parameter int unsigned SCAN_DIV       = 50000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic [3:0] module_sel
);

   localparam int unsigned SLOT_W = 16;
   localparam int unsigned CNT_W  = 8;
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]  DB_TARGET = CNT_W'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      S_SCAN     = 2'd0,
      S_PRESS_DB = 2'd1,
      S_HOLD     = 2'd2,
      S_REL_DB   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        row_meta_q, row_sync_q;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        col_idx_q, col_idx_d;
   logic [1:0]        row_idx_q, row_idx_d;
   logic [3:0]        col_q, col_d;
   logic              key_valid_q, key_valid_d;
   logic [3:0]        key_code_q, key_code_d;
   logic [3:0]        module_sel_q, module_sel_d;

   logic              sample_c;
   logic              any_low_c;
   logic              row_low_c;
   logic [1:0]        first_row_c;
   logic [CNT_W-1:0]  cnt_inc_c;
   logic              db_done_c;
   logic [3:0]        code_c;

   // Decision helpers; everything looks at the synchronized rows only.
   always_comb begin
      sample_c    = (slot_q == SLOT_LAST);
      any_low_c   = ~(&row_sync_q);
      row_low_c   = ~row_sync_q[row_idx_q];
      cnt_inc_c   = cnt_q + CNT_W'(1);
      db_done_c   = (cnt_inc_c == DB_TARGET);
      code_c      = {row_idx_q, col_idx_q};
      first_row_c = 2'd0;
      // Descending walk so the lowest-index low row wins.
      for (int i = 3; i >= 0; i--) begin
         if (!row_sync_q[i]) first_row_c = 2'(i);
      end
   end

   // Free-running slot counter; state changes never restart it.
   always_comb begin
      slot_d = sample_c ? '0 : slot_q + SLOT_W'(1);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_SCAN;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      if (sample_c) begin
         case (state_q)
            S_SCAN:     if (any_low_c) state_d = S_PRESS_DB;
            S_PRESS_DB: if (!row_low_c) state_d = S_SCAN;
                        else if (db_done_c) state_d = S_HOLD;
            S_HOLD:     if (!row_low_c) state_d = S_REL_DB;
            S_REL_DB:   if (row_low_c) state_d = S_HOLD;
                        else if (db_done_c) state_d = S_SCAN;
            default:    state_d = S_SCAN;
         endcase
      end
   end

   // Output / datapath logic.
   always_comb begin
      col_idx_d    = col_idx_q;
      row_idx_d    = row_idx_q;
      cnt_d        = cnt_q;
      key_valid_d  = 1'b0;
      key_code_d   = key_code_q;
      module_sel_d = module_sel_q;
      if (sample_c) begin
         case (state_q)
            S_SCAN: begin
               if (any_low_c) begin
                  row_idx_d = first_row_c;
                  cnt_d     = '0;
               end else begin
                  col_idx_d = col_idx_q + 2'd1;
               end
            end
            S_PRESS_DB: begin
               if (row_low_c) begin
                  cnt_d = cnt_inc_c;
                  if (db_done_c) begin
                     key_valid_d = 1'b1;
                     key_code_d  = code_c;
                     if (code_c < 4'd4)        module_sel_d = 4'b0001 << code_c[1:0];
                     else if (code_c == 4'd12) module_sel_d = 4'b0000;
                  end
               end else begin
                  col_idx_d = col_idx_q + 2'd1;
               end
            end
            S_HOLD: begin
               if (!row_low_c) cnt_d = '0;
            end
            S_REL_DB: begin
               if (!row_low_c) begin
                  cnt_d = cnt_inc_c;
                  if (db_done_c) col_idx_d = col_idx_q + 2'd1;
               end
            end
            default: ;
         endcase
      end
      col_d = ~(4'b0001 << col_idx_d);
   end

   // Synchronizer, slot counter and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_meta_q   <= 4'b1111;
         row_sync_q   <= 4'b1111;
         slot_q       <= '0;
         cnt_q        <= '0;
         col_idx_q    <= 2'd0;
         row_idx_q    <= 2'd0;
         col_q        <= 4'b1110;
         key_valid_q  <= 1'b0;
         key_code_q   <= 4'd0;
         module_sel_q <= 4'd0;
      end else begin
         row_meta_q   <= row;
         row_sync_q   <= row_meta_q;
         slot_q       <= slot_d;
         cnt_q        <= cnt_d;
         col_idx_q    <= col_idx_d;
         row_idx_q    <= row_idx_d;
         col_q        <= col_d;
         key_valid_q  <= key_valid_d;
         key_code_q   <= key_code_d;
         module_sel_q <= module_sel_d;
      end
   end

   assign col        = col_q;
   assign key_valid  = key_valid_q;
   assign key_code   = key_code_q;
   assign module_sel = module_sel_q;

endmodule

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
// tb_keypad_scanner: self-checking bench with a 4x4 keypad model, a
// scoreboard queue of expected key events and a table of key presses.
module tb_keypad_scanner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [3:0]  module_sel;
   logic [15:0] keys;

   int checks   = 0;
   int failures = 0;
   int pulse_cnt = 0;
   logic kv_prev = 1'b0;

   typedef struct packed {
      logic [3:0] code;
      logic [3:0] sel;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   typedef struct {
      logic [15:0] keys;
      bit          pulse;
      logic [3:0]  code;
      logic [3:0]  sel;
   } vec_t;
   vec_t vecs[9];

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .row        (row),
      .col        (col),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .module_sel (module_sel)
   );

   always #5 clk = ~clk;

   // Keypad matrix: a pressed key pulls its row low while its column is driven low.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard consumer: every key_valid pulse must match the queue head.
   always @(negedge clk) begin
      if (key_valid === 1'b1) begin
         check("kv_single_cycle", 32'(kv_prev), 32'd0);
         if (exp_q.size() == 0) begin
            check("kv_unexpected", 32'(exp_q.size()), 32'd1);
         end else begin
            mon_e = exp_q.pop_front();
            check("kv_code", 32'(key_code), 32'(mon_e.code));
            check("kv_sel", 32'(module_sel), 32'(mon_e.sel));
         end
         pulse_cnt++;
      end
      kv_prev = key_valid;
   end

   task automatic wait_pulse(input int start, input int budget);
      int n = 0;
      while (pulse_cnt == start && n < budget) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Align to the first cycle of the slot in which col becomes target.
   task automatic wait_col_start(input logic [3:0] target);
      int n = 0;
      while (col == target && n < 40) begin @(negedge clk); n++; end
      n = 0;
      while (col != target && n < 40) begin @(negedge clk); n++; end
      check("col_align", 32'(col), 32'(target));
   endtask

   initial begin
      int start;
      logic [3:0] exp_col;
      logic [3:0] exp_sel;

      vecs[0] = '{16'h0002, 1'b1, 4'd1,  4'b0010};
      vecs[1] = '{16'h0008, 1'b1, 4'd3,  4'b1000};
      vecs[2] = '{16'h1000, 1'b1, 4'd12, 4'b0000};
      vecs[3] = '{16'h0020, 1'b1, 4'd5,  4'b0000};
      vecs[4] = '{16'h0110, 1'b1, 4'd4,  4'b0000};
      vecs[5] = '{16'h0004, 1'b1, 4'd2,  4'b0100};
      vecs[6] = '{16'h0001, 1'b1, 4'd0,  4'b0001};
      vecs[7] = '{16'h8000, 1'b1, 4'd15, 4'b0001};
      vecs[8] = '{16'h0000, 1'b0, 4'd15, 4'b0001};

      keys  = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_col", 32'(col), 32'h0000000E);
      check("rst_kv", 32'(key_valid), 32'd0);
      check("rst_code", 32'(key_code), 32'd0);
      check("rst_sel", 32'(module_sel), 32'd0);
      rst_n = 1'b1;

      // Idle scan: one column per 4 clocks.
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         exp_col = ~(4'b0001 << (i % 4));
         check("idle_col", 32'(col), 32'(exp_col));
         repeat (4) @(negedge clk);
      end
      check("idle_sel", 32'(module_sel), 32'd0);
      check("idle_no_pulse", 32'(pulse_cnt), 32'd0);

      // Table-driven presses.
      for (int v = 0; v < 9; v++) begin
         start = pulse_cnt;
         if (vecs[v].pulse) exp_q.push_back('{code: vecs[v].code, sel: vecs[v].sel});
         keys = vecs[v].keys;
         wait_pulse(start, 64);
         check("vec_pulse", 32'(pulse_cnt - start), vecs[v].pulse ? 32'd1 : 32'd0);
         if (vecs[v].pulse) begin
            @(negedge clk);
            exp_col = ~(4'b0001 << vecs[v].code[1:0]);
            check("vec_col_hold", 32'(col), 32'(exp_col));
         end
         keys = '0;
         repeat (40) @(negedge clk);
         check("vec_code_held", 32'(key_code), 32'(vecs[v].code));
         check("vec_sel_held", 32'(module_sel), 32'(vecs[v].sel));
         check("vec_queue_empty", 32'(exp_q.size()), 32'd0);
      end
      exp_sel = 4'b0001;

      // Short press: detect plus one confirming sample, then release.
      start = pulse_cnt;
      wait_col_start(4'b1101);
      keys[1] = 1'b1;
      repeat (8) @(negedge clk);
      check("short_col_held", 32'(col), 32'h0000000D);
      keys = '0;
      repeat (4) @(negedge clk);
      check("short_col_adv", 32'(col), 32'h0000000B);
      repeat (20) @(negedge clk);
      check("short_no_pulse", 32'(pulse_cnt - start), 32'd0);

      // Release glitch in HOLD must not retrigger; a full release must.
      start = pulse_cnt;
      exp_q.push_back('{code: 4'd6, sel: exp_sel});
      keys[6] = 1'b1;
      wait_pulse(start, 64);
      repeat (8) @(negedge clk);
      keys = '0;
      repeat (4) @(negedge clk);
      keys[6] = 1'b1;
      repeat (24) @(negedge clk);
      check("glitch_col_hold", 32'(col), 32'h0000000B);
      check("glitch_one_pulse", 32'(pulse_cnt - start), 32'd1);
      keys = '0;
      repeat (40) @(negedge clk);
      exp_q.push_back('{code: 4'd6, sel: exp_sel});
      keys[6] = 1'b1;
      wait_pulse(start + 1, 64);
      check("repress_pulse", 32'(pulse_cnt - start), 32'd2);
      keys = '0;
      repeat (40) @(negedge clk);

      // Reset while debouncing a press of key 9.
      start = pulse_cnt;
      wait_col_start(4'b1101);
      keys[9] = 1'b1;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_col", 32'(col), 32'h0000000E);
      check("mid_rst_kv", 32'(key_valid), 32'd0);
      check("mid_rst_code", 32'(key_code), 32'd0);
      check("mid_rst_sel", 32'(module_sel), 32'd0);
      keys = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_col", 32'(col), 32'h0000000E);
      repeat (40) @(negedge clk);
      check("post_rst_no_pulse", 32'(pulse_cnt - start), 32'd0);
      check("post_rst_code", 32'(key_code), 32'd0);
      exp_q.push_back('{code: 4'd9, sel: 4'b0000});
      keys[9] = 1'b1;
      wait_pulse(start, 64);
      check("fresh_pulse", 32'(pulse_cnt - start), 32'd1);
      keys = '0;
      repeat (40) @(negedge clk);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      check("final_code", 32'(key_code), 32'd9);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 50000, clk cycles per column slot (legal range 2..65535).
REQ-002 SHALL provide parameter DEBOUNCE_SCANS, default 4, consecutive matching slot samples needed to confirm press or release (legal range 1..255).
REQ-003 SHALL provide port clk, input, 1, single system clock; every flop is on its rising edge.
REQ-004 SHALL provide port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL provide port row, input, 4, keypad row lines: active-low, externally pulled up, asynchronous to clk.
REQ-006 SHALL provide port col, output, 4, keypad column drive: active-low, at most one bit low at a time.
REQ-007 SHALL provide port key_valid, output, 1, one-cycle pulse on each confirmed press.
REQ-008 SHALL provide port key_code, output, 4, row*4+col of the last confirmed key; held between presses.
REQ-009 SHALL provide port module_sel, output, 4, one-hot peripheral select (bit n drives one downstream module enable); all zero means none selected.

Function
REQ-010 SHALL pass row through a two-flop synchronizer, reset value 4'b1111; all decisions use the synchronized value (rs).
REQ-011 SHALL run a slot counter 0..SCAN_DIV-1 that wraps to 0; a "sample" occurs in the cycle where the counter equals SCAN_DIV-1.
REQ-012 SHALL implement FSM states SCAN, PRESS_DB, HOLD and REL_DB.
REQ-013 SCAN: col SHALL advance 1110->1101->1011->0111->1110 after each sample with rs==4'b1111; on a sample with any rs bit low, the FSM SHALL latch the column index and the lowest-index low row, hold col fixed, clear the debounce count, and go to PRESS_DB.
REQ-014 PRESS_DB: on each sample where the latched row is still low, the count SHALL increment; on reaching DEBOUNCE_SCANS the FSM SHALL go to HOLD; on a sample where the latched row is high it SHALL return to SCAN and advance col.
REQ-015 On the PRESS_DB->HOLD transition, key_valid SHALL be 1 for exactly the next cycle, and key_code and module_sel SHALL update in that same cycle.
REQ-016 module_sel update: code 0..3 SHALL load one-hot (1<<code); code 12 SHALL load 4'b0000; all other codes SHALL leave module_sel unchanged.
REQ-017 HOLD: col SHALL stay fixed; on the first sample with the latched row high, the FSM SHALL clear the count and go to REL_DB.
REQ-018 REL_DB: each sample with the latched row high SHALL increment the count; on reaching DEBOUNCE_SCANS the FSM SHALL go to SCAN and advance col; a sample with the row low SHALL return to HOLD with no new key_valid.
REQ-019 Multiple keys pressed SHALL yield only the first key detected; other keys SHALL be ignored until release completes.
REQ-020 The slot counter SHALL free-run through every state transition; it SHALL not be restarted by state changes.
REQ-021 Samples SHALL be evaluated only at slot end; row activity between samples SHALL have no effect.

Reset
REQ-022 rst_n low SHALL immediately force: col=4'b1110, key_valid=0, key_code=0, module_sel=0, state SCAN, slot and debounce counters 0, synchronizer 4'b1111.
REQ-023 Reset asserted mid-debounce or mid-hold SHALL discard the pending key; after release, scanning SHALL restart at column 0 with no key_valid pulse.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=3)
REQ-024 Bench SHALL cover: reset, then no key -> col cycles 1110,1101,1011,0111 every 4 clk; key_valid never 1; module_sel=0.
REQ-025 Bench SHALL cover: hold row0 low at col1 -> detect on the col1 sample, then 3 further confirming samples (12 clk), then a single key_valid pulse, key_code=1, module_sel=4'b0010; col held 1101 until release debounced.
REQ-026 Bench SHALL cover: row0 low at col1 for only 2 samples, then released -> no key_valid; return to SCAN, col advances to 1011.
REQ-027 Bench SHALL cover: select key 3 (module_sel=1000), then key 12 -> module_sel=0000, key_code=12; then key 5 -> key_valid pulses, key_code=5, module_sel stays 0000.
REQ-028 Bench SHALL cover: during HOLD, release for 1 sample then re-press -> no second key_valid; a full 3-sample release then re-press -> a second pulse.
REQ-029 Bench SHALL cover: rows 1 and 2 both low at col0 -> key_code=4; rst_n pulsed during PRESS_DB -> all outputs at reset values and no key_valid afterward until a fresh debounced press.
